// File: rtl/demux_route_sequencer.sv
// demux_route_sequencer
// Upstream feeder for a 1-to-16 demultiplexer stage. Routing requests
// (bit, destination) are accepted over valid/ready into a small FIFO and
// replayed onto the demux data/selector pins. Each route is held for HOLD
// cycles, and a guard cycle follows it so the selector never moves while
// the demux data input is high.
//
// Optional feature: define DEMUX_ROUTE_SEQUENCER_STATS_EN to add the
// sent_count[7:0] output, which counts completed routes and wraps at 255.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready is combinational on rst)
//   req_bit/req_dest  data bit and destination index of the request
//   dmx_in            demux data input
//   dmx_selector      demux selector
//   dmx_strobe        high while a route is being driven
//   busy              sequencer active or requests buffered
//   fifo_count        current FIFO occupancy
//   sent_count        completed routes (stats build only)
module demux_route_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned SEL_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_bit,
  input  logic [SEL_W-1:0]           req_dest,
  output logic                       dmx_in,
  output logic [SEL_W-1:0]           dmx_selector,
  output logic                       dmx_strobe,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef DEMUX_ROUTE_SEQUENCER_STATS_EN
  ,
  output logic [7:0]                 sent_count
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = SEL_W + 1;
  localparam int unsigned HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // FIFO storage: entry = {bit, dest}
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] head;

  logic push;
  logic pop;

  state_t              state;
  state_t              state_nxt;
  logic [HCNT_W-1:0]   hold_cnt;
  logic [HCNT_W-1:0]   hold_nxt;
  logic                in_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic                strobe_nxt;
  logic                busy_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                route_done;

  // Ready depends only on registered occupancy; a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign req_ready = !rst && (fifo_count != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];

  // FIFO data array (pointers flushed by reset, contents need no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_bit, req_dest};
    end
  end

  // State register plus registered outputs and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      dmx_in       <= 1'b0;
      dmx_selector <= '0;
      dmx_strobe   <= 1'b0;
      busy         <= 1'b0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      dmx_in       <= in_nxt;
      dmx_selector <= sel_nxt;
      dmx_strobe   <= strobe_nxt;
      busy         <= busy_nxt;
      fifo_count   <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Next-state logic and pop decision
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    route_done = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          route_done = 1'b1;
          state_nxt  = GAP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    in_nxt     = 1'b0;
    sel_nxt    = dmx_selector;
    strobe_nxt = 1'b0;
    hold_nxt   = hold_cnt;
    if (pop) begin
      // Selector only moves here; dmx_in is 0 in IDLE and GAP.
      in_nxt     = head[ENT_W-1];
      sel_nxt    = head[SEL_W-1:0];
      strobe_nxt = 1'b1;
      hold_nxt   = HCNT_W'(HOLD - 1);
    end else if (state == DRIVE && !route_done) begin
      in_nxt     = dmx_in;
      strobe_nxt = 1'b1;
      hold_nxt   = hold_cnt - HCNT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase

    busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
  end

`ifdef DEMUX_ROUTE_SEQUENCER_STATS_EN
  // Completed-route counter; a route cut short by reset never reaches GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= 8'd0;
    end else if (route_done) begin
      sent_count <= sent_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_route_sequencer.sv
// Randomized and directed bench for demux_route_sequencer. A queue-based
// reference model tracks each route as a countdown of remaining cycles
// (HOLD drive cycles followed by one guard cycle).
module tb_demux_route_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_bit;
  logic [SEL_W-1:0] req_dest;
  logic             dmx_in;
  logic [SEL_W-1:0] dmx_selector;
  logic             dmx_strobe;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
`ifdef DEMUX_ROUTE_SEQUENCER_STATS_EN
  logic [7:0]       sent_count;
`endif

  demux_route_sequencer #(
    .DEPTH(DEPTH),
    .HOLD (HOLD),
    .SEL_W(SEL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bit     (req_bit),
    .req_dest    (req_dest),
    .dmx_in      (dmx_in),
    .dmx_selector(dmx_selector),
    .dmx_strobe  (dmx_strobe),
    .busy        (busy),
    .fifo_count  (fifo_count)
`ifdef DEMUX_ROUTE_SEQUENCER_STATS_EN
    ,
    .sent_count  (sent_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SEL_W:0]   q[$];
  int               timer;      // cycles left in current route incl. guard
  logic             cur_bit;
  logic [SEL_W-1:0] cur_sel;
  int               sent;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    timer   = 0;
    cur_bit = 1'b0;
    cur_sel = '0;
    sent    = 0;
  endtask

  // One clock of the behavioural model, using inputs present at the edge.
  task automatic model_step(input logic r, input logic v, input logic b, input logic [SEL_W-1:0] d);
    bit full;
    logic [SEL_W:0] e;
    if (r) begin
      model_reset();
    end else begin
      full = (q.size() == DEPTH);
      if (timer == 2) sent = (sent + 1) % 256;
      if (timer <= 1 && q.size() > 0) begin
        e       = q.pop_front();
        cur_bit = e[SEL_W];
        cur_sel = e[SEL_W-1:0];
        timer   = HOLD + 1;
      end else if (timer > 0) begin
        timer--;
      end
      if (v && !full) q.push_back({b, d});
    end
  endtask

  // Check outputs, apply new inputs, advance one clock in DUT and model.
  task automatic cycle(input logic r, input logic v, input logic b, input logic [SEL_W-1:0] d);
    logic exp_strobe;
    @(negedge clk);
    exp_strobe = (timer >= 2);
    check_eq("dmx_strobe", 32'(dmx_strobe), 32'(exp_strobe));
    check_eq("dmx_in", 32'(dmx_in), 32'(exp_strobe && cur_bit));
    check_eq("dmx_selector", 32'(dmx_selector), 32'(cur_sel));
    check_eq("busy", 32'(busy), 32'((timer > 0) || (q.size() > 0)));
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
`ifdef DEMUX_ROUTE_SEQUENCER_STATS_EN
    check_eq("sent_count", 32'(sent_count), 32'(sent));
`endif
    rst       = r;
    req_valid = v;
    req_bit   = b;
    req_dest  = d;
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(!r && (q.size() != DEPTH)));
    @(posedge clk);
    model_step(r, v, b, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_bit   = 1'b0;
    req_dest  = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Single route with guard cycle and return to idle
    cycle(1'b0, 1'b1, 1'b1, 4'b0001);
    idle(6);

    // Two back-to-back requests, second carries bit 0
    cycle(1'b0, 1'b1, 1'b1, 4'b1111);
    cycle(1'b0, 1'b1, 1'b0, 4'b1010);
    idle(9);

    // Hold valid until the FIFO fills and ready drops
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, i[0], SEL_W'(i));
    idle(16);

    // Reset in the middle of a route with entries buffered
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, SEL_W'(i + 5));
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle(6);

    // Five requests so the write pointer wraps
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, SEL_W'(15 - i));
    idle(20);

    // Saturated traffic: enough routes to wrap the route counter
    for (int i = 0; i < 820; i++)
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 15)));

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 15)));
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
